// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//  - MDU_XLEN     : default operand/result width
//  - MDU_MUL..    : funct3 encodings of the M-extension ops
//  - mdu_state_e  : sequencer FSM states (3-bit encoding)
package mdu_pkg;

  localparam int unsigned MDU_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared unsigned multiply / restoring-divide datapath.
// Ports:
//  acc_i     accumulator, 2*XLEN+1 bits
//             mul: {carry+high (XLEN+1), low/multiplier (XLEN)}
//             div: {remainder (XLEN+1), quotient/dividend (XLEN)}
//  operand_i |A| for multiply, |B| for divide
//  is_div_i  selects the divide step
//  acc_o     accumulator after one step
module mdu_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN:0] acc_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            is_div_i,
  output logic [2*XLEN:0] acc_o
);

  logic [XLEN:0] hi_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_sub;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current multiplier bit is set.
    hi_sum  = acc_i[2*XLEN:XLEN] + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide: remainder after shifting in the next dividend bit.
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    rem_sub = rem_sh - {1'b0, operand_i};
    if (is_div_i) begin
      if (rem_sh >= {1'b0, operand_i}) begin
        acc_o = {rem_sub, acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh, acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, hi_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide controller. Accepts one M-op, runs XLEN iterations of a
// shared shift-add / restoring-divide datapath, then applies sign fix-up. Divide-by-zero
// and signed-overflow divides are resolved without iterating.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  start_i     M-op issue strobe; funct3_i/rs1_i/rs2_i latched on the accepting edge
//  kill_i      pipeline flush, abandons any op and blocks a same-cycle start
//  busy_o      op in flight (PREP/ITER/FIX)
//  stall_o     freezes PC/decode while an op is in flight or being issued
//  done_o      one-cycle result-valid pulse
//  result_o    result, held until the next completed op
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            neg_a_q, neg_b_q;
  logic [XLEN-1:0] opnd_q;
  logic [2*XLEN:0] acc_q, acc_step;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            is_div;
  logic            sign_a_en, sign_b_en;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  assign accept = start_i & ~kill_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign is_div = op_q[2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_i) state_d = S_PREP;
        S_PREP:  state_d = special ? S_DONE : S_ITER;
        S_ITER:  if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = start_i ? S_PREP : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q == S_PREP) | (state_q == S_ITER) | (state_q == S_FIX);
    done_o   = (state_q == S_DONE);
    stall_o  = busy_o | (start_i & ~busy_o & ~kill_i);
    result_o = result_q;
  end

  // Operand preparation and special-case detection, evaluated in PREP on latched operands.
  always_comb begin
    sign_a_en = 1'b0;
    sign_b_en = 1'b0;
    unique case (op_q)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        sign_a_en = 1'b1;
        sign_b_en = 1'b1;
      end
      MDU_MULHSU: sign_a_en = 1'b1;
      default: ;
    endcase
    neg_a    = sign_a_en & a_q[XLEN-1];
    neg_b    = sign_b_en & b_q[XLEN-1];
    abs_a    = neg_a ? -a_q : a_q;
    abs_b    = neg_b ? -b_q : b_q;
    div_zero = is_div & (b_q == '0);
    // Only the signed divides can overflow (MIN_INT / -1).
    div_ovf  = is_div & ~op_q[0] & (a_q == MinInt) & (b_q == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = op_q[1] ? a_q : '1;
    end else begin
      special_res = op_q[1] ? '0 : MinInt;
    end
  end

  mdu_iter_step #(
    .XLEN (XLEN)
  ) u_iter_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div),
    .acc_o     (acc_step)
  );

  // Sign fix-up and result select
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    // Remainder sign follows the dividend.
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      MDU_MUL:                        fix_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              fix_res = quot_fix;
      default:                        fix_res = rem_fix;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= funct3_i;
        a_q  <= rs1_i;
        b_q  <= rs2_i;
      end
      // A flush must leave result_q untouched, so nothing advances under kill.
      if (!kill_i) begin
        case (state_q)
          S_PREP: begin
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= is_div ? abs_b : abs_a;
            acc_q   <= {{(XLEN+1){1'b0}}, (is_div ? abs_a : abs_b)};
            cnt_q   <= CNT_W'(XLEN-1);
            if (special) result_q <= special_res;
          end
          S_ITER: begin
            acc_q <= acc_step;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          S_FIX:   result_q <= fix_res;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  mdu_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] MIN = 32'h8000_0000;

  // Reference: RISC-V M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (f >= 3'd4 && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Issues one op and returns at the negedge where done_o is seen;
  // lat counts rising edges from the accepting edge to the one that samples done_o.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit stall_ok);
    lat      = -1;
    res      = '0;
    stall_ok = 1'b1;
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done_o) begin
        lat = n;
        res = result_o;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    int lat;
    logic [31:0] res;
    bit sok;
    run_op(f, a, b, lat, res, sok);
    check({tag, "_res"}, res, ref_result(f, a, b));
    check({tag, "_lat"}, 32'(lat), 32'(ref_latency(f, a, b)));
  endtask

  initial begin
    int lat, lat2;
    logic [31:0] res, res2, last_res, a, b;
    logic [2:0] f;
    bit sok, seen;

    rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    funct3_i = '0; rs1_i = '0; rs2_i = '0;
    #3;
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL with latency and stall tracking
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, res, sok);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", 32'(lat), 32'd35);
    check("mul_stall", {31'b0, sok}, 32'd1);
    check("mul_done_busy", {31'b0, busy_o}, 32'd0);

    op_check("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check("mulh_const", result_o, 32'h4000_0000);
    op_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_const", result_o, 32'hFFFF_FFFE);
    op_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    check("mulhsu_const", result_o, 32'hFFFF_FFFF);
    op_check("div_by0", 3'd4, 32'd5, 32'd0);
    op_check("rem_by0", 3'd6, 32'd5, 32'd0);
    check("rem_by0_const", result_o, 32'd5);
    op_check("div_ovf", 3'd4, MIN, 32'hFFFF_FFFF);
    op_check("rem_ovf", 3'd6, MIN, 32'hFFFF_FFFF);
    op_check("divu", 3'd5, 32'd100, 32'd7);
    check("divu_const", result_o, 32'd14);
    op_check("remu", 3'd7, 32'd100, 32'd7);
    op_check("div_neg", 3'd4, -32'sd7, 32'd2);
    check("div_neg_const", result_o, 32'hFFFF_FFFD);
    op_check("rem_neg", 3'd6, -32'sd7, 32'd2);
    check("rem_neg_const", result_o, 32'hFFFF_FFFF);
    op_check("mul_zero", 3'd0, 32'd0, 32'h1234_5678);

    // kill and start in the same cycle: not accepted
    funct3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; start_i = 1'b1; kill_i = 1'b1;
    check("kill_start_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1 start_i = 1'b0; kill_i = 1'b0;
    check("kill_start_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);

    // Kill during the 10th ITER cycle
    last_res = result_o;
    funct3_i = 3'd0; rs1_i = 32'd1234; rs2_i = 32'd5678; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (11) @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    check("kill_busy", {31'b0, busy_o}, 32'd0);
    check("kill_done", {31'b0, done_o}, 32'd0);
    check("kill_result", result_o, last_res);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("kill_no_done", {31'b0, seen}, 32'd0);
    op_check("after_kill", 3'd0, 32'd3, 32'd4);
    check("after_kill_const", result_o, 32'd12);

    // Async reset mid-ITER
    funct3_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: second start issued in the DONE cycle
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, lat, res, sok);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1000, lat2, res2, sok);
    check("b2b_res1", res, ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    check("b2b_res2", res2, ref_result(3'd7, 32'hDEAD_BEEF, 32'd1000));
    check("b2b_gap", 32'(lat2), 32'd35);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = MIN;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      op_check("rand", f, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
